// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | instr_fetch_unit_if : memory read port and decode handshake bundle      |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
interface instr_fetch_unit_if #(
   parameter int MEM_WIDTH = 32,
   parameter int AW        = 8
);
   logic [AW-1:0]        mem_addr;
   logic                 mem_read_en;
   logic                 mem_write_en;
   logic [MEM_WIDTH-1:0] mem_write_val;
   logic [MEM_WIDTH-1:0] mem_read_val;
   logic                 inst_valid;
   logic                 inst_ready;
   logic [MEM_WIDTH-1:0] inst_word;
   logic [31:0]          inst_pc;

   modport master (
      output mem_addr, mem_read_en, mem_write_en, mem_write_val,
      input  mem_read_val,
      output inst_valid, inst_word, inst_pc,
      input  inst_ready
   );

   modport slave (
      input  mem_addr, mem_read_en, mem_write_en, mem_write_val,
      output mem_read_val,
      input  inst_valid, inst_word, inst_pc,
      output inst_ready
   );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | instr_fetch_unit : fetch initiator with prefetch FIFO and redirect      |
// | Optional IFETCH_PERF_CNT_EN adds fetch/stall performance counters.      |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module instr_fetch_unit #(
   parameter int          MEM_WIDTH  = 32,
   parameter int          MEM_SIZE   = 256,
   parameter int          FIFO_DEPTH = 2,
   parameter int unsigned RESET_ADDR = 0
) (
   input  wire logic                        clk,
   input  wire logic                        reset_n,
   instr_fetch_unit_if.master               bus,
   input  wire logic                        halt,
   input  wire logic                        redirect_valid,
   input  wire logic [$clog2(MEM_SIZE)-1:0] redirect_addr
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0]                      perf_fetch_cnt,
   output logic [31:0]                      perf_stall_cnt
`endif
);
   localparam int AW = $clog2(MEM_SIZE);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [AW-1:0] PC_LAST = AW'(MEM_SIZE - 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [AW-1:0]        pc;
   logic [PW-1:0]        rd_ptr;
   logic [PW-1:0]        wr_ptr;
   logic [CW-1:0]        count;
   logic [MEM_WIDTH-1:0] fifo_word [FIFO_DEPTH];
   logic [AW-1:0]        fifo_pc   [FIFO_DEPTH];
   logic                 flush;
   logic                 pop;
   logic                 space;
   logic                 fetch;
   logic                 not_empty;

   assign not_empty      = (count != '0);
   assign flush          = redirect_valid & (state != IDLE);
   assign bus.inst_valid = not_empty & ~redirect_valid;
   assign pop            = bus.inst_valid & bus.inst_ready;
   // A pop frees its slot in the same cycle, so a full FIFO still sustains one fetch per clock.
   assign space          = (count < DEPTH_C) | pop;
   assign fetch          = (state == RUN) & ~halt & ~redirect_valid & space;

   assign bus.mem_addr      = pc;
   assign bus.mem_read_en   = fetch;
   assign bus.mem_write_en  = 1'b0;
   assign bus.mem_write_val = '0;
   assign bus.inst_word     = not_empty ? fifo_word[rd_ptr] : '0;
   assign bus.inst_pc       = not_empty ? 32'({fifo_pc[rd_ptr], 2'b00}) : 32'd0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = RUN;
         RUN:     if (halt)  state_nxt = HALTED;
         HALTED:  if (!halt) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc     <= AW'(RESET_ADDR);
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         pc     <= redirect_addr;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (fetch) begin
            pc     <= (pc == PC_LAST) ? '0 : pc + 1'b1;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({fetch, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (fetch) begin
         fifo_word[wr_ptr] <= bus.mem_read_val;
         fifo_pc[wr_ptr]   <= pc;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (fetch) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
         if ((state == RUN) & ~halt & ~redirect_valid & ~space)
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Self-checking bench for instr_fetch_unit: directed scenarios then random traffic,
// each cycle compared against a queue-based reference model.
module tb_instr_fetch_unit;
   localparam int MW = 32;
   localparam int MS = 256;
   localparam int AW = 8;
   localparam int FD = 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          halt;
   logic          redirect_valid;
   logic [AW-1:0] redirect_addr;
   logic [MW-1:0] mem [MS];
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0]   perf_fetch_cnt;
   logic [31:0]   perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   instr_fetch_unit_if #(.MEM_WIDTH(MW), .AW(AW)) bus ();

   assign bus.mem_read_val = mem[bus.mem_addr];

   instr_fetch_unit #(
      .MEM_WIDTH (MW),
      .MEM_SIZE  (MS),
      .FIFO_DEPTH(FD),
      .RESET_ADDR(0)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .halt          (halt),
      .redirect_valid(redirect_valid),
      .redirect_addr (redirect_addr)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   // reference model state
   int          q_pc [$];
   logic [MW-1:0] q_w [$];
   int          m_pc;
   bit          started;
   bit          halted_last;
   int unsigned m_fetch_cnt;
   int unsigned m_stall_cnt;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q_pc.delete();
      q_w.delete();
      m_pc        = 0;
      started     = 0;
      halted_last = 0;
      m_fetch_cnt = 0;
      m_stall_cnt = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_addr"},  64'(bus.mem_addr), 64'd0);
      chk({tag, "_rden"},  64'(bus.mem_read_en), 64'd0);
      chk({tag, "_wren"},  64'(bus.mem_write_en), 64'd0);
      chk({tag, "_valid"}, 64'(bus.inst_valid), 64'd0);
      chk({tag, "_word"},  64'(bus.inst_word), 64'd0);
      chk({tag, "_pc"},    64'(bus.inst_pc), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
      chk({tag, "_pfetch"}, 64'(perf_fetch_cnt), 64'd0);
      chk({tag, "_pstall"}, 64'(perf_stall_cnt), 64'd0);
`endif
   endtask

   // One clock: apply inputs, compare outputs at the falling edge, advance the model at the rising edge.
   task automatic step(input bit rdy, input bit h, input bit rv, input int ra);
      bit exp_valid, pop, space, running, fetch;
      bus.inst_ready = rdy;
      halt           = h;
      redirect_valid = rv;
      redirect_addr  = AW'(ra);
      @(negedge clk);
      exp_valid = (q_pc.size() != 0) && !rv;
      pop       = exp_valid && rdy;
      space     = (q_pc.size() < FD) || pop;
      running   = started && !halted_last;
      fetch     = running && !h && !rv && space;
      chk("mem_addr",    64'(bus.mem_addr), 64'(m_pc));
      chk("mem_read_en", 64'(bus.mem_read_en), 64'(fetch));
      chk("mem_write",   {31'd0, bus.mem_write_en, bus.mem_write_val}, 64'd0);
      chk("inst_valid",  64'(bus.inst_valid), 64'(exp_valid));
      if (exp_valid) begin
         chk("inst_word", 64'(bus.inst_word), 64'(q_w[0]));
         chk("inst_pc",   64'(bus.inst_pc), 64'(q_pc[0] * 4));
      end
`ifdef IFETCH_PERF_CNT_EN
      chk("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fetch_cnt));
      chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stall_cnt));
`endif
      @(posedge clk);
      if (!started) begin
         started     = 1;
         halted_last = 0;
      end else begin
         if (rv) begin
            q_pc.delete();
            q_w.delete();
            m_pc = ra;
         end else begin
            if (pop) begin
               void'(q_pc.pop_front());
               void'(q_w.pop_front());
            end
            if (fetch) begin
               q_pc.push_back(m_pc);
               q_w.push_back(mem[m_pc]);
               m_pc = (m_pc + 1) % MS;
            end
         end
         if (fetch) m_fetch_cnt++;
         if (running && !h && !rv && !space) m_stall_cnt++;
         halted_last = h;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < MS; i++) mem[i] = 32'hA000_0000 + i;
      reset_n        = 1'b0;
      bus.inst_ready = 1'b1;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 reset_n = 1'b1;

      // sequential stream with decode always ready
      repeat (10) step(1, 0, 0, 0);
      // decode back-pressure fills the FIFO, then drains
      repeat (5) step(0, 0, 0, 0);
      repeat (6) step(1, 0, 0, 0);
      // redirect to 0x40 while full
      repeat (3) step(0, 0, 0, 0);
      step(0, 0, 1, 'h40);
      repeat (5) step(1, 0, 0, 0);
      // fetch across the address wrap
      step(1, 0, 1, 'hFE);
      repeat (6) step(1, 0, 0, 0);
      // halt with two entries queued
      repeat (3) step(0, 0, 0, 0);
      repeat (4) step(1, 1, 0, 0);
      repeat (5) step(1, 0, 0, 0);
      // redirect while halted, then resume
      step(1, 1, 0, 0);
      step(1, 1, 1, 'h10);
      repeat (4) step(1, 0, 0, 0);

      // asynchronous reset mid-stream
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      @(posedge clk);
      #1 reset_n = 1'b1;
      model_reset();
      repeat (6) step(1, 0, 0, 0);

      // random traffic
      for (int i = 0; i < MS; i++) mem[i] = $urandom;
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 9) < 7,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 19) == 0,
              int'($urandom_range(0, MS - 1)));
      end
      step(1, 0, 1, MS - 1);
      repeat (8) step(1, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
